// File: rtl/pixel_out_writer_pkg.sv
// Shared types and default sizing for the pixel output writer and its RAM.
package pixel_out_writer_pkg;

  localparam int PIX_WIDTH = 24;
  localparam int PIX_DEPTH = 24;
  localparam int VEC_LANES = 4;

  typedef logic [PIX_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_out_ram.sv
// Single write port, asynchronous read pixel array; kept apart so it can become block RAM.
module pixel_out_ram
  import pixel_out_writer_pkg::*;
#(
  parameter int WIDTH = PIX_WIDTH,
  parameter int DEPTH = PIX_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset so a frame survives a writer reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_out_writer.sv
// Accepts pixel vectors over valid/ready and stores mask-selected lanes one per cycle
// into a sequentially filled output memory, with a combinational dump port.
module pixel_out_writer
  import pixel_out_writer_pkg::*;
#(
  parameter int WIDTH = PIX_WIDTH,
  parameter int DEPTH = PIX_DEPTH,
  parameter int LANES = VEC_LANES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         vec_valid,
  output logic                         vec_ready,
  input  logic [LANES*WIDTH-1:0]       vec_data,
  input  logic [LANES-1:0]             vec_mask,
  input  logic [WIDTH-1:0]             rd_addr,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         done,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES-1);

  state_t               state;
  logic [CW-1:0]        wptr;
  logic [CW-1:0]        wptr_inc;
  logic [LW-1:0]        lidx;
  logic [LANES*WIDTH-1:0] vec_q;
  logic [LANES-1:0]     mask_q;

  logic                 handshake;
  logic                 room;
  logic                 lane_wr;
  logic                 last_lane;
  logic                 ram_we;
  logic [WIDTH-1:0]     lane_data;
  logic [WIDTH-1:0]     ram_rdata;

  assign handshake = vec_valid & vec_ready;
  assign room      = (wptr < DEPTH_C);
  assign lane_wr   = mask_q[lidx] & room;
  assign last_lane = (lidx == LAST_LANE);
  assign wptr_inc  = wptr + CW'(1);
  assign lane_data = vec_q[lidx*WIDTH +: WIDTH];

  // A start pulse kills the lane being drained in the same cycle.
  assign ram_we = (state == DRAIN) && !start && lane_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wptr      <= '0;
      lidx      <= '0;
      vec_q     <= '0;
      mask_q    <= '0;
      vec_ready <= 1'b1;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            vec_q     <= vec_data;
            mask_q    <= vec_mask;
            lidx      <= '0;
            state     <= DRAIN;
            vec_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (mask_q[lidx]) begin
            if (room) begin
              wptr <= wptr_inc;
              if (wptr_inc == DEPTH_C) begin
                done <= 1'b1;
              end
            end else begin
              overflow <= 1'b1;
            end
          end
          lidx <= lidx + LW'(1);
          if (last_lane) begin
            lidx <= '0;
            if ((lane_wr ? wptr_inc : wptr) == DEPTH_C) begin
              state <= FULL;
            end else begin
              state     <= IDLE;
              vec_ready <= 1'b1;
            end
          end
        end
        FULL: begin
          state <= FULL;
        end
        default: begin
          state     <= IDLE;
          vec_ready <= 1'b1;
        end
      endcase

      // start overrides everything except a handshake accepted in the same IDLE cycle,
      // which then writes from address zero of the new frame.
      if (start) begin
        wptr     <= '0;
        lidx     <= '0;
        done     <= 1'b0;
        overflow <= 1'b0;
        if (!((state == IDLE) && handshake)) begin
          state     <= IDLE;
          vec_ready <= 1'b1;
        end
      end
    end
  end

  pixel_out_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr[AW-1:0]),
    .wdata (lane_data),
    .raddr (rd_addr[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign rd_data = (rd_addr < WIDTH'(DEPTH)) ? ram_rdata : '0;
  assign count   = wptr;

endmodule

// File: tb/tb_pixel_out_writer.sv
// Directed, table-driven bench for pixel_out_writer: frame fill, compaction, overflow,
// start and reset in mid-drain, and the dump read port.
module tb_pixel_out_writer;
  import pixel_out_writer_pkg::*;

  localparam int WIDTH = 24;
  localparam int DEPTH = 24;
  localparam int LANES = 4;
  localparam int VW    = LANES*WIDTH;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             vec_valid;
  logic             vec_ready;
  logic [VW-1:0]    vec_data;
  logic [LANES-1:0] vec_mask;
  logic [WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [4:0]       count;
  logic             done;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          st;
    logic [3:0]    mask;
    logic [VW-1:0] data;
    logic [4:0]    cnt;
    logic          dn;
    logic          ovf;
    logic          rdy;
  } vec_rec_t;

  vec_rec_t tbl [13];

  pixel_out_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .vec_mask  (vec_mask),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .count     (count),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mk(input pixel_t base);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = base + pixel_t'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkMem(input int addr, input logic [23:0] exp);
    rd_addr = 24'(addr);
    #1;
    checkOutput($sformatf("mem[%0d]", addr), 32'(rd_data), 32'(exp));
  endtask

  // Offers one vector, waits (bounded) for the handshake, then lets all lanes drain.
  task automatic applyStimulus(input logic st, input logic [3:0] mask, input logic [VW-1:0] data);
    int n;
    if (st) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    vec_mask  = mask;
    vec_data  = data;
    vec_valid = 1'b1;
    n = 0;
    while (!vec_ready && n < 20) begin
      tick();
      n++;
    end
    if (!vec_ready) begin
      checkOutput("handshake timeout", 32'(vec_ready), 32'd1);
      vec_valid = 1'b0;
      return;
    end
    tick();
    vec_valid = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int first;
    int second;
    logic saw;

    rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0;
    vec_data = '0; vec_mask = '0; rd_addr = '0;

    for (int v = 0; v < 6; v++)
      tbl[v] = '{1'b0, 4'hF, mk(pixel_t'(v*4)), 5'(4*(v+1)), (v == 5), 1'b0, (v != 5)};
    tbl[6] = '{1'b1, 4'hF, mk(24'h200), 5'd4, 1'b0, 1'b0, 1'b1};
    for (int k = 1; k < 5; k++)
      tbl[6+k] = '{1'b0, 4'hF, mk(pixel_t'(24'h200 + 4*k)), 5'(4*(k+1)), 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 4'h3, mk(24'h220), 5'd22, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 4'hF, mk(24'h300), 5'd24, 1'b1, 1'b1, 1'b0};

    repeat (2) tick();
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset ready", 32'(vec_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Full frame from the table
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].st, tbl[i].mask, tbl[i].data);
      checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
      checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].dn));
      checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].ovf));
      checkOutput($sformatf("vec%0d ready", i), 32'(vec_ready), 32'(tbl[i].rdy));
    end
    for (int a = 0; a < DEPTH; a++) checkMem(a, 24'(a));
    checkMem(24, 24'h0);
    checkMem(24'hFFFFFF, 24'h0);
    checkMem(5, 24'h5);

    // Start clears the frame; memory stays
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start count", 32'(count), 32'd0);
    checkOutput("start done", 32'(done), 32'd0);
    checkOutput("start ready", 32'(vec_ready), 32'd1);

    // Mask compaction
    applyStimulus(1'b0, 4'b1010, {24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA});
    checkOutput("compact count", 32'(count), 32'd2);
    checkOutput("compact ready", 32'(vec_ready), 32'd1);
    checkMem(0, 24'hBBBBBB);
    checkMem(1, 24'hDDDDDD);
    checkMem(2, 24'h000002);

    // Handshake period with valid held high and an empty mask
    vec_mask = 4'b0000; vec_data = '0; vec_valid = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 30 && second < 0; c++) begin
      if (vec_ready) begin
        if (first < 0) first = c;
        else second = c;
      end
      tick();
    end
    vec_valid = 1'b0;
    repeat (4) tick();
    checkOutput("handshake period", 32'(second - first), 32'd5);
    checkOutput("empty mask count", 32'(count), 32'd2);

    // Overflow frame from the table
    for (int i = 6; i < 13; i++) begin
      applyStimulus(tbl[i].st, tbl[i].mask, tbl[i].data);
      checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
      checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].dn));
      checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].ovf));
      checkOutput($sformatf("vec%0d ready", i), 32'(vec_ready), 32'(tbl[i].rdy));
    end
    checkMem(21, 24'h221);
    checkMem(22, 24'h300);
    checkMem(23, 24'h301);

    // FULL ignores vec_valid
    vec_mask = 4'hF; vec_data = mk(24'h777); vec_valid = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      if (vec_ready) saw = 1'b1;
      tick();
    end
    vec_valid = 1'b0;
    checkOutput("full no handshake", 32'(saw), 32'd0);
    checkOutput("full count hold", 32'(count), 32'd24);
    checkMem(0, 24'h200);

    // start in the middle of a drain
    start = 1'b1;
    tick();
    start = 1'b0;
    vec_mask = 4'hF; vec_data = mk(24'h400); vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    tick();
    checkOutput("lane0 count", 32'(count), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("mid start count", 32'(count), 32'd0);
    checkOutput("mid start ready", 32'(vec_ready), 32'd1);
    checkOutput("mid start overflow", 32'(overflow), 32'd0);
    repeat (3) tick();
    checkOutput("mid start no writes", 32'(count), 32'd0);
    checkMem(0, 24'h400);
    checkMem(1, 24'h201);
    checkMem(3, 24'h203);
    applyStimulus(1'b0, 4'hF, mk(24'h500));
    checkOutput("restart count", 32'(count), 32'd4);
    checkMem(0, 24'h500);
    checkMem(3, 24'h503);

    // Async reset in the middle of a drain
    vec_mask = 4'hF; vec_data = mk(24'h600); vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset count", 32'(count), 32'd0);
    checkOutput("mid reset done", 32'(done), 32'd0);
    checkOutput("mid reset overflow", 32'(overflow), 32'd0);
    checkOutput("mid reset ready", 32'(vec_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    checkMem(0, 24'h500);
    checkMem(4, 24'h600);
    checkMem(5, 24'h601);
    checkMem(6, 24'h206);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_out_writer.md
# pixel_out_writer

Output-side counterpart of the pixel input memory. Accepts processed pixel vectors from the vector datapath over a valid/ready handshake and stores them one lane per cycle into an internal output pixel memory. Stores are compacted by lane mask, with a sequential write pointer. Exposes a combinational read port so the testbench or host can dump the frame, and flags completion when DEPTH pixels have been written.

## Interface
- WIDTH, 24, bits per pixel word (RGB888)
- DEPTH, 24, pixel words in the output memory
- LANES, 4, pixels per input vector
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; restarts a frame
- vec_valid  in  1  vector offered
- vec_ready  out  1  block can accept a vector
- vec_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- vec_mask  in  LANES  lane i is stored only if vec_mask[i]=1
- rd_addr  in  WIDTH  dump read address
- rd_data  out  WIDTH  mem[rd_addr]; 0 if rd_addr >= DEPTH
- count  out  $clog2(DEPTH+1)  pixels written this frame (write pointer)
- done  out  1  high once count == DEPTH
- overflow  out  1  sticky; a masked-in lane was dropped because memory was full

## Operation
- States:
  - IDLE: vec_ready=1.
  - DRAIN: vec_ready=0; holds the latched vector and lane index lidx.
  - FULL: vec_ready=0, done=1.
- Reset (async):
  - State IDLE; wptr=0, lidx=0, done=0, overflow=0.
  - vec_ready=1 once reset is released.
  - Memory contents are not cleared.
- IDLE, vec_valid & vec_ready: latch vec_data/vec_mask, lidx=0, go DRAIN.
- DRAIN, each cycle:
  - If mask[lidx]=1 and wptr<DEPTH: mem[wptr] <= lane lidx, wptr++.
  - If mask[lidx]=1 and wptr==DEPTH: set overflow; the lane is discarded.
  - lidx++.
- Masked-out lanes still consume one cycle. Latency is fixed, independent of mask.
- Leaving DRAIN, on the cycle lidx==LANES-1:
  - If the resulting wptr==DEPTH, go FULL.
  - Otherwise go IDLE.
- FULL: remains until start. vec_valid is ignored; no handshake occurs.
- start (any state):
  - Next state IDLE; wptr=0, done=0, overflow=0.
  - A vector latched in DRAIN is discarded.
  - start has priority over all other transitions.
- start together with a valid handshake in IDLE: the vector is accepted and written from address 0.
- Pointer arithmetic: wptr never exceeds DEPTH and never wraps.
- Read port: rd_data = (rd_addr < DEPTH) ? mem[rd_addr] : 0, fully combinational.

## Timing
- Handshake completes on the edge where vec_valid & vec_ready are both 1.
- Lane 0 is written on the next edge. Lane k is written k+1 edges after the handshake.
- vec_ready returns high LANES+1 cycles after the handshake. Max throughput is one vector per LANES+1 cycles.
- done rises in the cycle after the write of word DEPTH-1.
- count updates on the same edge as each write.
- Read during write of the same address: rd_data shows the old value until the write edge, then the new value the following cycle.
- vec_valid may drop without acceptance; no requirement to hold.

## Structure
- The shared package holds:
  - typedef pixel_t (logic [WIDTH-1:0]).
  - The state enum {IDLE, DRAIN, FULL}.
  - Default constants PIX_WIDTH=24, PIX_DEPTH=24, VEC_LANES=4, used by the processor top.
- One sub-module is natural: pixel_out_ram, a single-write-port, asynchronous-read array with a write enable, kept separate so it can map to block RAM later.
- The FSM, lane counter, pointer and flags live in pixel_out_writer.

## Test plan
- Reset: pull rst_n low mid-DRAIN.
  - Immediately: vec_ready=0→1 behaviour is IDLE, count=0, done=0, overflow=0.
  - Previously written memory words keep their values.
- Full frame, all lanes:
  - Stimulus: 6 vectors, mask=4'b1111, lane i of vector v = 24'h(v*4+i).
  - Required: mem[0..23] = 0..23, done=1 one cycle after the 6th vector's last lane, vec_ready=0.
  - Each vector_ready gap is exactly 5 cycles.
- Mask compaction:
  - Stimulus: mask=4'b1010, data lanes {24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA}.
  - Required: mem[0]=BBBBBB, mem[1]=DDDDDD, count=2; vec_ready high again after 5 cycles.
- Overflow:
  - Stimulus: fill to count=22, then send mask=4'b1111.
  - Required: 2 lanes stored, count=24, done=1, overflow=1.
  - A further vec_valid gets no handshake.
- start mid-DRAIN:
  - Stimulus: pulse start at lane 1.
  - Required: count=0 next cycle, remaining lanes not written, vec_ready=1; a new vector then writes from address 0.
- Read port: rd_addr=24 and 24'hFFFFFF return 0; rd_addr=5 returns mem[5] combinationally in the same cycle.
